// File: rtl/psx_mem_arbiter_if.sv
// Bundle of the two client request ports, the broadcast read-data return
// and the downstream DDR-bridge request/response signals.
interface psx_mem_arbiter_if;
   logic         i_cmdA;
   logic         i_cmdB;
   logic         i_writeElseReadA;
   logic         i_writeElseReadB;
   logic [1:0]   i_commandSizeA;
   logic [1:0]   i_commandSizeB;
   logic [14:0]  i_targetAddrA;
   logic [14:0]  i_targetAddrB;
   logic [2:0]   i_subAddrA;
   logic [2:0]   i_subAddrB;
   logic [15:0]  i_writeMaskA;
   logic [15:0]  i_writeMaskB;
   logic [255:0] i_dataA;
   logic [255:0] i_dataB;
   logic         o_busyA;
   logic         o_busyB;
   logic         o_dataValidA;
   logic         o_dataValidB;
   logic [255:0] o_dataClient;

   logic         o_command;
   logic         o_writeElseRead;
   logic [1:0]   o_commandSize;
   logic [14:0]  o_targetAddr;
   logic [2:0]   o_subAddr;
   logic [15:0]  o_writeMask;
   logic [255:0] o_data;
   logic         i_busyClient;
   logic         i_dataValidClient;
   logic [255:0] i_dataClient;

   modport slave (
      input  i_cmdA, i_cmdB, i_writeElseReadA, i_writeElseReadB,
      input  i_commandSizeA, i_commandSizeB, i_targetAddrA, i_targetAddrB,
      input  i_subAddrA, i_subAddrB, i_writeMaskA, i_writeMaskB,
      input  i_dataA, i_dataB,
      output o_busyA, o_busyB, o_dataValidA, o_dataValidB, o_dataClient,
      output o_command, o_writeElseRead, o_commandSize, o_targetAddr,
      output o_subAddr, o_writeMask, o_data,
      input  i_busyClient, i_dataValidClient, i_dataClient
   );

   modport master (
      output i_cmdA, i_cmdB, i_writeElseReadA, i_writeElseReadB,
      output i_commandSizeA, i_commandSizeB, i_targetAddrA, i_targetAddrB,
      output i_subAddrA, i_subAddrB, i_writeMaskA, i_writeMaskB,
      output i_dataA, i_dataB,
      input  o_busyA, o_busyB, o_dataValidA, o_dataValidB, o_dataClient,
      input  o_command, o_writeElseRead, o_commandSize, o_targetAddr,
      input  o_subAddr, o_writeMask, o_data,
      output i_busyClient, i_dataValidClient, i_dataClient
   );
endinterface

// File: rtl/psx_mem_arbiter.sv
// Two-client arbiter in front of the DDR bridge: one-entry slot per client,
// a single outstanding downstream transaction, read data broadcast back.
module psx_mem_arbiter #(
   parameter int RR_ENABLE = 1
) (
   input logic                i_clk,
   input logic                i_rst,
   psx_mem_arbiter_if.slave   bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT_RD = 2'd1;
   localparam logic [1:0] WAIT_WR = 2'd2;

   typedef struct packed {
      logic         wr;
      logic [1:0]   size;
      logic [14:0]  addr;
      logic [2:0]   sub;
      logic [15:0]  mask;
      logic [255:0] data;
   } req_t;

   logic [1:0] state;
   logic       full_a;
   logic       full_b;
   req_t       slot_a;
   req_t       slot_b;
   req_t       last_out;
   req_t       req_a;
   req_t       req_b;
   req_t       granted;
   req_t       drive;
   logic       last_grant_b;
   logic       owner_b;
   logic       issue;
   logic       grant_b;

   always_comb begin
      req_a   = '{wr: bus.i_writeElseReadA, size: bus.i_commandSizeA,
                  addr: bus.i_targetAddrA, sub: bus.i_subAddrA,
                  mask: bus.i_writeMaskA, data: bus.i_dataA};
      req_b   = '{wr: bus.i_writeElseReadB, size: bus.i_commandSizeB,
                  addr: bus.i_targetAddrB, sub: bus.i_subAddrB,
                  mask: bus.i_writeMaskB, data: bus.i_dataB};
      issue   = (state == IDLE) && !bus.i_busyClient && (full_a || full_b) && !i_rst;
      grant_b = full_b && (!full_a || ((RR_ENABLE != 0) && !last_grant_b));
      granted = grant_b ? slot_b : slot_a;
      drive   = issue ? granted : last_out;
   end

   // Downstream fields hold the last granted request between issues.
   assign bus.o_command       = issue;
   assign bus.o_writeElseRead = drive.wr;
   assign bus.o_commandSize   = drive.size;
   assign bus.o_targetAddr    = drive.addr;
   assign bus.o_subAddr       = drive.sub;
   assign bus.o_writeMask     = drive.mask;
   assign bus.o_data          = drive.data;

   assign bus.o_busyA      = full_a && !i_rst;
   assign bus.o_busyB      = full_b && !i_rst;
   assign bus.o_dataClient = bus.i_dataClient;
   assign bus.o_dataValidA = (state == WAIT_RD) && bus.i_dataValidClient && !owner_b && !i_rst;
   assign bus.o_dataValidB = (state == WAIT_RD) && bus.i_dataValidClient &&  owner_b && !i_rst;

   always_ff @(posedge i_clk) begin
      if (bus.i_cmdA && !full_a) slot_a <= req_a;
      if (bus.i_cmdB && !full_b) slot_b <= req_b;
   end

   // lastGrant only moves on a contested grant, so a lone request never
   // steals the next turn from the other client.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         full_a       <= 1'b0;
         full_b       <= 1'b0;
         last_grant_b <= 1'b1;
         owner_b      <= 1'b0;
         last_out     <= '0;
      end else begin
         if (bus.i_cmdA && !full_a)    full_a <= 1'b1;
         else if (issue && !grant_b)   full_a <= 1'b0;
         if (bus.i_cmdB && !full_b)    full_b <= 1'b1;
         else if (issue && grant_b)    full_b <= 1'b0;

         case (state)
            IDLE: begin
               if (issue) begin
                  last_out <= granted;
                  owner_b  <= grant_b;
                  if (full_a && full_b) last_grant_b <= grant_b;
                  state    <= granted.wr ? WAIT_WR : WAIT_RD;
               end
            end
            WAIT_RD: if (bus.i_dataValidClient) state <= IDLE;
            WAIT_WR: if (!bus.i_busyClient)     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psx_mem_arbiter.sv
// Directed scenario bench for psx_mem_arbiter: one round-robin and one
// fixed-priority instance sharing clock and reset.
module tb_psx_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   logic [255:0] d_rd  = {8{32'hA5A5_0001}};
   logic [255:0] d_wr  = {8{32'h1234_5678}};
   logic [255:0] d_rd2 = {8{32'h0BAD_F00D}};

   always #5 clk = ~clk;

   psx_mem_arbiter_if bus_rr();
   psx_mem_arbiter_if bus_fp();

   psx_mem_arbiter #(.RR_ENABLE(1)) dut_rr (.i_clk(clk), .i_rst(rst), .bus(bus_rr));
   psx_mem_arbiter #(.RR_ENABLE(0)) dut_fp (.i_clk(clk), .i_rst(rst), .bus(bus_fp));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic init_inputs();
      bus_rr.i_cmdA = 0; bus_rr.i_cmdB = 0;
      bus_rr.i_writeElseReadA = 0; bus_rr.i_writeElseReadB = 0;
      bus_rr.i_commandSizeA = 0; bus_rr.i_commandSizeB = 0;
      bus_rr.i_targetAddrA = 0; bus_rr.i_targetAddrB = 0;
      bus_rr.i_subAddrA = 0; bus_rr.i_subAddrB = 0;
      bus_rr.i_writeMaskA = 0; bus_rr.i_writeMaskB = 0;
      bus_rr.i_dataA = 0; bus_rr.i_dataB = 0;
      bus_rr.i_busyClient = 0; bus_rr.i_dataValidClient = 0; bus_rr.i_dataClient = 0;
      bus_fp.i_cmdA = 0; bus_fp.i_cmdB = 0;
      bus_fp.i_writeElseReadA = 0; bus_fp.i_writeElseReadB = 0;
      bus_fp.i_commandSizeA = 0; bus_fp.i_commandSizeB = 0;
      bus_fp.i_targetAddrA = 0; bus_fp.i_targetAddrB = 0;
      bus_fp.i_subAddrA = 0; bus_fp.i_subAddrB = 0;
      bus_fp.i_writeMaskA = 0; bus_fp.i_writeMaskB = 0;
      bus_fp.i_dataA = 0; bus_fp.i_dataB = 0;
      bus_fp.i_busyClient = 0; bus_fp.i_dataValidClient = 0; bus_fp.i_dataClient = 0;
   endtask

   task automatic test_reset();
      bus_rr.i_cmdA = 1;
      step(); settle();
      tests++; if (bus_rr.o_busyA !== 1'b0) begin fails++; $display("[TB] FAIL reset_busyA got %0b want 0", bus_rr.o_busyA); end
      tests++; if (bus_rr.o_busyB !== 1'b0) begin fails++; $display("[TB] FAIL reset_busyB got %0b want 0", bus_rr.o_busyB); end
      tests++; if (bus_rr.o_command !== 1'b0) begin fails++; $display("[TB] FAIL reset_command got %0b want 0", bus_rr.o_command); end
      tests++; if ({bus_rr.o_dataValidA, bus_rr.o_dataValidB} !== 2'b00) begin fails++; $display("[TB] FAIL reset_dataValid got %b want 00", {bus_rr.o_dataValidA, bus_rr.o_dataValidB}); end
      tests++; if (bus_fp.o_command !== 1'b0) begin fails++; $display("[TB] FAIL reset_fp_command got %0b want 0", bus_fp.o_command); end
      bus_rr.i_cmdA = 0;
      rst = 0;
      step();
   endtask

   task automatic test_single_read();
      int seen;
      seen = 0;
      bus_rr.i_writeElseReadA = 0; bus_rr.i_commandSizeA = 2'd1;
      bus_rr.i_targetAddrA = 15'h0010; bus_rr.i_subAddrA = 3'd0; bus_rr.i_cmdA = 1;
      step(); bus_rr.i_cmdA = 0; settle();
      tests++; if (bus_rr.o_busyA !== 1'b1) begin fails++; $display("[TB] FAIL single_busyA got %0b want 1", bus_rr.o_busyA); end
      tests++; if (bus_rr.o_command !== 1'b1) begin fails++; $display("[TB] FAIL single_command got %0b want 1", bus_rr.o_command); end
      tests++; if (bus_rr.o_commandSize !== 2'd1) begin fails++; $display("[TB] FAIL single_size got %0d want 1", bus_rr.o_commandSize); end
      tests++; if (bus_rr.o_targetAddr !== 15'h0010) begin fails++; $display("[TB] FAIL single_addr got %0h want 10", bus_rr.o_targetAddr); end
      tests++; if (bus_rr.o_writeElseRead !== 1'b0) begin fails++; $display("[TB] FAIL single_wr got %0b want 0", bus_rr.o_writeElseRead); end
      step(); settle();
      tests++; if ({bus_rr.o_command, bus_rr.o_busyA} !== 2'b00) begin fails++; $display("[TB] FAIL single_after_issue cmd,busyA got %b want 00", {bus_rr.o_command, bus_rr.o_busyA}); end
      for (int i = 0; i < 5; i++) begin
         step(); settle();
         if (bus_rr.o_command || bus_rr.o_dataValidA || bus_rr.o_dataValidB) seen++;
      end
      tests++; if (seen !== 0) begin fails++; $display("[TB] FAIL single_quiet_wait got %0d events want 0", seen); end
      bus_rr.i_dataValidClient = 1; bus_rr.i_dataClient = d_rd; settle();
      tests++; if (bus_rr.o_dataValidA !== 1'b1) begin fails++; $display("[TB] FAIL single_validA got %0b want 1", bus_rr.o_dataValidA); end
      tests++; if (bus_rr.o_dataValidB !== 1'b0) begin fails++; $display("[TB] FAIL single_validB got %0b want 0", bus_rr.o_dataValidB); end
      tests++; if (bus_rr.o_dataClient !== d_rd) begin fails++; $display("[TB] FAIL single_data got %0h want %0h", bus_rr.o_dataClient, d_rd); end
      step(); settle();
      tests++; if (bus_rr.o_dataValidA !== 1'b0) begin fails++; $display("[TB] FAIL idle_valid_dropped got %0b want 0", bus_rr.o_dataValidA); end
      bus_rr.i_dataValidClient = 0;
      step();
   endtask

   task automatic test_round_robin();
      bus_rr.i_targetAddrA = 15'h0100; bus_rr.i_targetAddrB = 15'h0200;
      bus_rr.i_cmdA = 1; bus_rr.i_cmdB = 1;
      step(); bus_rr.i_cmdA = 0; bus_rr.i_cmdB = 0; settle();
      tests++; if (!(bus_rr.o_command === 1'b1 && bus_rr.o_targetAddr === 15'h0100)) begin fails++; $display("[TB] FAIL rr1_first cmd=%0b addr=%0h want 1/100", bus_rr.o_command, bus_rr.o_targetAddr); end
      step(); step(); settle();
      tests++; if ({bus_rr.o_command, bus_rr.o_busyB} !== 2'b01) begin fails++; $display("[TB] FAIL rr1_hold cmd,busyB got %b want 01", {bus_rr.o_command, bus_rr.o_busyB}); end
      bus_rr.i_dataValidClient = 1; settle();
      tests++; if ({bus_rr.o_dataValidA, bus_rr.o_dataValidB} !== 2'b10) begin fails++; $display("[TB] FAIL rr1_validA got %b want 10", {bus_rr.o_dataValidA, bus_rr.o_dataValidB}); end
      step(); bus_rr.i_dataValidClient = 0; settle();
      tests++; if (!(bus_rr.o_command === 1'b1 && bus_rr.o_targetAddr === 15'h0200)) begin fails++; $display("[TB] FAIL rr1_second cmd=%0b addr=%0h want 1/200", bus_rr.o_command, bus_rr.o_targetAddr); end
      step(); bus_rr.i_dataValidClient = 1; settle();
      tests++; if ({bus_rr.o_dataValidA, bus_rr.o_dataValidB} !== 2'b01) begin fails++; $display("[TB] FAIL rr1_validB got %b want 01", {bus_rr.o_dataValidA, bus_rr.o_dataValidB}); end
      step(); bus_rr.i_dataValidClient = 0;
      bus_rr.i_targetAddrA = 15'h0101; bus_rr.i_targetAddrB = 15'h0201;
      bus_rr.i_cmdA = 1; bus_rr.i_cmdB = 1;
      step(); bus_rr.i_cmdA = 0; bus_rr.i_cmdB = 0; settle();
      tests++; if (!(bus_rr.o_command === 1'b1 && bus_rr.o_targetAddr === 15'h0201)) begin fails++; $display("[TB] FAIL rr2_first cmd=%0b addr=%0h want 1/201", bus_rr.o_command, bus_rr.o_targetAddr); end
      step(); bus_rr.i_dataValidClient = 1; settle();
      tests++; if (bus_rr.o_dataValidB !== 1'b1) begin fails++; $display("[TB] FAIL rr2_validB got %0b want 1", bus_rr.o_dataValidB); end
      step(); bus_rr.i_dataValidClient = 0; settle();
      tests++; if (!(bus_rr.o_command === 1'b1 && bus_rr.o_targetAddr === 15'h0101)) begin fails++; $display("[TB] FAIL rr2_second cmd=%0b addr=%0h want 1/101", bus_rr.o_command, bus_rr.o_targetAddr); end
      step(); bus_rr.i_dataValidClient = 1; settle();
      tests++; if (bus_rr.o_dataValidA !== 1'b1) begin fails++; $display("[TB] FAIL rr2_validA got %0b want 1", bus_rr.o_dataValidA); end
      step(); bus_rr.i_dataValidClient = 0;
      step();
   endtask

   task automatic test_fixed_priority();
      bus_fp.i_targetAddrA = 15'h0300; bus_fp.i_targetAddrB = 15'h0400;
      for (int r = 0; r < 2; r++) begin
         bus_fp.i_cmdA = 1; bus_fp.i_cmdB = 1;
         step(); bus_fp.i_cmdA = 0; bus_fp.i_cmdB = 0; settle();
         tests++; if (!(bus_fp.o_command === 1'b1 && bus_fp.o_targetAddr === 15'h0300)) begin fails++; $display("[TB] FAIL fp%0d_first cmd=%0b addr=%0h want 1/300", r, bus_fp.o_command, bus_fp.o_targetAddr); end
         step(); bus_fp.i_dataValidClient = 1; settle();
         step(); bus_fp.i_dataValidClient = 0; settle();
         tests++; if (!(bus_fp.o_command === 1'b1 && bus_fp.o_targetAddr === 15'h0400)) begin fails++; $display("[TB] FAIL fp%0d_second cmd=%0b addr=%0h want 1/400", r, bus_fp.o_command, bus_fp.o_targetAddr); end
         step(); bus_fp.i_dataValidClient = 1; settle();
         tests++; if (bus_fp.o_dataValidB !== 1'b1) begin fails++; $display("[TB] FAIL fp%0d_validB got %0b want 1", r, bus_fp.o_dataValidB); end
         step(); bus_fp.i_dataValidClient = 0;
         step();
      end
   endtask

   task automatic test_write_busy();
      int bad;
      bad = 0;
      bus_rr.i_busyClient = 1;
      bus_rr.i_writeElseReadB = 1; bus_rr.i_commandSizeB = 2'd2; bus_rr.i_targetAddrB = 15'h0055;
      bus_rr.i_subAddrB = 3'd3; bus_rr.i_writeMaskB = 16'h00F0; bus_rr.i_dataB = d_wr; bus_rr.i_cmdB = 1;
      step(); bus_rr.i_cmdB = 0;
      for (int i = 0; i < 5; i++) begin
         settle();
         if (bus_rr.o_busyB !== 1'b1 || bus_rr.o_command !== 1'b0) bad++;
         step();
      end
      tests++; if (bad !== 0) begin fails++; $display("[TB] FAIL wr_hold_while_busy got %0d bad cycles want 0", bad); end
      bus_rr.i_busyClient = 0; settle();
      tests++; if (!(bus_rr.o_command === 1'b1 && bus_rr.o_writeElseRead === 1'b1 && bus_rr.o_commandSize === 2'd2)) begin fails++; $display("[TB] FAIL wr_issue cmd=%0b wr=%0b size=%0d want 1/1/2", bus_rr.o_command, bus_rr.o_writeElseRead, bus_rr.o_commandSize); end
      tests++; if (!(bus_rr.o_subAddr === 3'd3 && bus_rr.o_targetAddr === 15'h0055)) begin fails++; $display("[TB] FAIL wr_addr sub=%0d addr=%0h want 3/55", bus_rr.o_subAddr, bus_rr.o_targetAddr); end
      tests++; if (!(bus_rr.o_writeMask === 16'h00F0 && bus_rr.o_data === d_wr)) begin fails++; $display("[TB] FAIL wr_mask_data mask=%0h data=%0h want 00f0/%0h", bus_rr.o_writeMask, bus_rr.o_data, d_wr); end
      step(); settle();
      tests++; if ({bus_rr.o_command, bus_rr.o_busyB} !== 2'b00) begin fails++; $display("[TB] FAIL wr_after_issue cmd,busyB got %b want 00", {bus_rr.o_command, bus_rr.o_busyB}); end
      bus_rr.i_busyClient = 1; bus_rr.i_targetAddrA = 15'h0077; bus_rr.i_cmdA = 1;
      step(); bus_rr.i_cmdA = 0; settle();
      tests++; if (bus_rr.o_command !== 1'b0) begin fails++; $display("[TB] FAIL wr_wait_no_cmd got %0b want 0", bus_rr.o_command); end
      bus_rr.i_busyClient = 0;
      step(); settle();
      tests++; if (!(bus_rr.o_command === 1'b1 && bus_rr.o_targetAddr === 15'h0077)) begin fails++; $display("[TB] FAIL wr_then_read cmd=%0b addr=%0h want 1/77", bus_rr.o_command, bus_rr.o_targetAddr); end
      step(); bus_rr.i_dataValidClient = 1; settle();
      tests++; if (bus_rr.o_dataValidA !== 1'b1) begin fails++; $display("[TB] FAIL wr_then_read_valid got %0b want 1", bus_rr.o_dataValidA); end
      step(); bus_rr.i_dataValidClient = 0;
      step();
   endtask

   task automatic test_ignore();
      bus_rr.i_busyClient = 1;
      bus_rr.i_writeElseReadA = 0; bus_rr.i_targetAddrA = 15'h00AA; bus_rr.i_cmdA = 1;
      step(); bus_rr.i_targetAddrA = 15'h0155;
      step(); bus_rr.i_cmdA = 0; settle();
      tests++; if (bus_rr.o_busyA !== 1'b1) begin fails++; $display("[TB] FAIL ign_busyA got %0b want 1", bus_rr.o_busyA); end
      bus_rr.i_busyClient = 0; settle();
      tests++; if (!(bus_rr.o_command === 1'b1 && bus_rr.o_targetAddr === 15'h00AA)) begin fails++; $display("[TB] FAIL ign_addr cmd=%0b addr=%0h want 1/aa", bus_rr.o_command, bus_rr.o_targetAddr); end
      step(); settle();
      tests++; if (bus_rr.o_busyA !== 1'b0) begin fails++; $display("[TB] FAIL ign_busy_cleared got %0b want 0", bus_rr.o_busyA); end
      bus_rr.i_dataValidClient = 1; settle();
      tests++; if (bus_rr.o_dataValidA !== 1'b1) begin fails++; $display("[TB] FAIL ign_validA got %0b want 1", bus_rr.o_dataValidA); end
      step(); bus_rr.i_dataValidClient = 0;
      step();
   endtask

   task automatic test_reset_mid();
      bus_rr.i_targetAddrA = 15'h00F0; bus_rr.i_cmdA = 1;
      step(); bus_rr.i_cmdA = 0; settle();
      tests++; if (bus_rr.o_command !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_issue got %0b want 1", bus_rr.o_command); end
      step();
      rst = 1;
      step(); settle();
      tests++; if ({bus_rr.o_busyA, bus_rr.o_command} !== 2'b00) begin fails++; $display("[TB] FAIL rstmid_in_reset busyA,cmd got %b want 00", {bus_rr.o_busyA, bus_rr.o_command}); end
      rst = 0;
      step(); bus_rr.i_dataValidClient = 1; bus_rr.i_dataClient = d_rd2; settle();
      tests++; if ({bus_rr.o_dataValidA, bus_rr.o_dataValidB} !== 2'b00) begin fails++; $display("[TB] FAIL rstmid_strobe got %b want 00", {bus_rr.o_dataValidA, bus_rr.o_dataValidB}); end
      tests++; if ({bus_rr.o_busyA, bus_rr.o_busyB} !== 2'b00) begin fails++; $display("[TB] FAIL rstmid_busy got %b want 00", {bus_rr.o_busyA, bus_rr.o_busyB}); end
      step(); bus_rr.i_dataValidClient = 0;
      bus_rr.i_writeElseReadB = 0; bus_rr.i_targetAddrB = 15'h0011; bus_rr.i_cmdB = 1;
      step(); bus_rr.i_cmdB = 0; settle();
      tests++; if (!(bus_rr.o_command === 1'b1 && bus_rr.o_targetAddr === 15'h0011)) begin fails++; $display("[TB] FAIL rstmid_idle_issue cmd=%0b addr=%0h want 1/11", bus_rr.o_command, bus_rr.o_targetAddr); end
      step(); bus_rr.i_dataValidClient = 1; settle();
      tests++; if (bus_rr.o_dataValidB !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_validB got %0b want 1", bus_rr.o_dataValidB); end
      step(); bus_rr.i_dataValidClient = 0;
      step();
   endtask

   initial begin
      init_inputs();
      rst = 1;
      step();
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed_priority();
      test_write_busy();
      test_ignore();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/psx_mem_arbiter.md
PSX_MEM_ARBITER -- requirements
Module: psx_mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: RR_ENABLE, default 1, meaning 1 = round-robin between clients and 0 = fixed priority with client A winning.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 i_clk  in  1  clock; all state updates on the rising edge.
REQ-004 i_rst  in  1  synchronous active-high reset.
REQ-005 i_cmdA / i_cmdB  in  1  client request strobe; sampled only when the matching o_busyA / o_busyB is 0.
REQ-006 i_writeElseReadA / i_writeElseReadB  in  1  0 = read, 1 = write.
REQ-007 i_commandSizeA / i_commandSizeB  in  2  0 = 8 byte, 1 = 32 byte, 2 = 4 byte.
REQ-008 i_targetAddrA / i_targetAddrB  in  15  32-byte block address.
REQ-009 i_subAddrA / i_subAddrB  in  3  4-byte word within the block.
REQ-010 i_writeMaskA / i_writeMaskB  in  16  per-16-bit write enable.
REQ-011 i_dataA / i_dataB  in  256  write data.
REQ-012 o_busyA / o_busyB  out  1  the client's pending slot is full.
REQ-013 o_dataValidA / o_dataValidB  out  1  one-cycle strobe: read data is valid for this client.
REQ-014 o_dataClient  out  256  read data, broadcast to both clients.
REQ-015 o_command, o_writeElseRead, o_commandSize[1:0], o_targetAddr[14:0], o_subAddr[2:0], o_writeMask[15:0], o_data[255:0]  out  downstream request to the DDR bridge.
REQ-016 i_busyClient  in  1  downstream busy signal.
REQ-017 i_dataValidClient  in  1  downstream one-cycle read-data strobe.
REQ-018 i_dataClient  in  256  downstream read data.

Function
REQ-019 Each client SHALL own a one-entry slot; when i_cmdX=1 and o_busyX=0, all request fields SHALL be registered into the slot and o_busyX SHALL be 1 from the next cycle.
REQ-020 i_cmdX asserted while o_busyX=1 SHALL be ignored; the slot contents SHALL be unchanged.
REQ-021 The FSM states SHALL be IDLE, WAIT_RD and WAIT_WR.
REQ-022 In IDLE with i_busyClient=0 and at least one slot full, the block SHALL assert o_command for exactly one cycle, driving the granted slot's fields on the downstream outputs, and SHALL clear that slot on the same edge.
REQ-023 After an issue, the FSM SHALL go to WAIT_RD for a read and to WAIT_WR for a write.
REQ-024 Grant: a single full slot SHALL win; if both slots are full, RR_ENABLE=1 SHALL grant the client not granted last (lastGrant register, reset value B, so A wins first) and RR_ENABLE=0 SHALL grant A.
REQ-025 WAIT_RD: on i_dataValidClient=1, the block SHALL pulse o_dataValid of the owner client (owner register set at issue) for that same cycle, combinationally, and the FSM SHALL return to IDLE.
REQ-026 WAIT_WR: the FSM SHALL stay for at least one cycle, then return to IDLE on the first cycle with i_busyClient=0.
REQ-027 o_command SHALL be 0 in every state other than IDLE, so at most one downstream transaction is outstanding.
REQ-028 o_dataClient SHALL equal i_dataClient at all times (pass-through).
REQ-029 i_dataValidClient outside WAIT_RD SHALL be dropped; no client strobe SHALL be produced.
REQ-030 Latency from client capture to o_command SHALL be at least 1 cycle, and exactly 1 cycle when IDLE, i_busyClient=0 and the other slot is empty or loses arbitration.
REQ-031 The slot SHALL clear on issue, and o_busyX SHALL read 0 the following cycle, so a client can re-request then; capture and issue never coincide for the same slot.
REQ-032 Downstream outputs other than o_command SHALL be don't-care when o_command=0, but SHALL hold the last granted values (no X).

Reset
REQ-033 While i_rst=1: FSM = IDLE, both slots empty, o_busyA/B = 0, o_dataValidA/B = 0, o_command = 0, lastGrant = B, owner = A.
REQ-034 A reset asserted mid-transaction SHALL abandon the transaction; a downstream read strobe arriving after reset SHALL be dropped per REQ-029.

Verification
REQ-035 A read of 32 bytes at addr 0x0010 issued alone, with downstream valid after 6 cycles -> o_command exactly 1 cycle after capture with size=1 and addr=0x0010; o_dataValidA pulses once with the data; o_dataValidB stays 0.
REQ-036 A and B request in the same cycle, RR_ENABLE=1 -> A issued first, B issued only after A completes; repeat both -> B issued first.
REQ-037 Same as REQ-036 with RR_ENABLE=0 -> A always issued first.
REQ-038 Client B writes 4 bytes at subAddr 3 while i_busyClient is held at 1 for 5 cycles -> o_busyB=1 throughout, no o_command while busy, issue on the first idle cycle with mask and data unchanged.
REQ-039 Second i_cmdA while o_busyA=1 with different addr -> ignored; the original addr is issued.
REQ-040 i_rst during WAIT_RD, then downstream valid arrives -> no client strobe, FSM in IDLE, both busy outputs 0.
